// File: rtl/instruction_mem_ctrl.sv
// Instruction memory controller.
// Holds the program image written by the boot loader through a streaming
// load port, and serves word-addressed fetches from the fetch stage with a
// fixed number of wait states. Any fetch at or beyond the loaded image
// length returns FAULT_INST with fetch_fault set.
//
// Handshake semantics (both ports):
//   load port  : a beat transfers on a rising edge where load_valid and
//                load_ready are both 1. load_ready is only ever 1 while the
//                controller is in the load session.
//   fetch port : a request is accepted on a rising edge where fetch_req and
//                fetch_ready are both 1 and load_en is 0; fetch_addr is
//                captured on that same edge. The answer is a single-cycle
//                inst_valid pulse with instruction/fetch_fault alongside.
//                There is no backpressure on the response side.
module instruction_mem_ctrl #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] FAULT_INST  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  // program-load port
  input  logic                       load_en,
  input  logic                       load_valid,
  input  logic [DATA_W-1:0]          load_data,
  output logic                       load_ready,
  output logic                       load_done,
  output logic [$clog2(DEPTH+1)-1:0] words_loaded,
  // fetch port
  input  logic                       fetch_req,
  input  logic [ADDR_W-1:0]          fetch_addr,
  output logic                       fetch_ready,
  output logic                       inst_valid,
  output logic [DATA_W-1:0]          instruction,
  output logic                       fetch_fault,
  // current controller state, for observation only
  output logic [1:0]                 state_dbg
);

  // Counter width covers 0..DEPTH inclusive (a full image).
  localparam int CNT_W = $clog2(DEPTH + 1);
  // Memory index width; at least one bit so a single-word memory still works.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Bounds compare is done at the wider of the two widths so that large
  // addresses never alias onto small ones.
  localparam int CMP_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        wait_cnt;

  // Image storage: deliberately not reset, only words_loaded says what is valid.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              load_beat;
  logic [CNT_W-1:0]  ptr_inc;
  logic              load_full;
  logic [CMP_W-1:0]  addr_ext;
  logic [CMP_W-1:0]  words_ext;
  logic              addr_hit;

  assign state_dbg = state;

  // Derived handshake and bounds signals.
  always_comb begin
    load_beat = 1'b0;
    ptr_inc   = ptr + 1'b1;
    load_full = 1'b0;
    addr_ext  = CMP_W'(addr_q);
    words_ext = CMP_W'(words_loaded);
    addr_hit  = 1'b0;
    if (state == ST_LOAD) begin
      load_beat = load_valid & load_ready;
    end
    // The beat that fills the last slot ends the session on its own.
    load_full = load_beat && (ptr_inc == CNT_W'(DEPTH));
    addr_hit  = (addr_ext < words_ext);
  end

  // Memory write port: one word per accepted load beat.
  always_ff @(posedge clk) begin
    if (load_beat) begin
      mem[ptr[IDX_W-1:0]] <= load_data;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      addr_q       <= '0;
      wait_cnt     <= '0;
      load_ready   <= 1'b0;
      load_done    <= 1'b0;
      words_loaded <= '0;
      fetch_ready  <= 1'b0;
      inst_valid   <= 1'b0;
      instruction  <= '0;
      fetch_fault  <= 1'b0;
    end else begin
      // Single-cycle pulses default low.
      inst_valid <= 1'b0;
      load_done  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (load_en) begin
            // Load has priority over a simultaneous fetch request; a new
            // session always starts writing at word 0.
            state       <= ST_LOAD;
            ptr         <= '0;
            load_ready  <= 1'b1;
            fetch_ready <= 1'b0;
          end else if (fetch_req && fetch_ready) begin
            addr_q      <= fetch_addr;
            wait_cnt    <= '0;
            fetch_ready <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state <= ST_WAIT;
            end else begin
              state <= ST_RESP;
            end
          end else begin
            // Also raises ready on the first cycle out of reset.
            fetch_ready <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (load_beat) begin
            ptr <= ptr_inc;
          end
          if (!load_en || load_full) begin
            // A beat on the closing cycle is stored and counted.
            words_loaded <= load_beat ? ptr_inc : ptr;
            load_done    <= 1'b1;
            ptr          <= '0;
            load_ready   <= 1'b0;
            fetch_ready  <= 1'b1;
            state        <= ST_IDLE;
          end
        end

        ST_WAIT: begin
          if (wait_cnt == 3'(WAIT_CYCLES - 1)) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          inst_valid  <= 1'b1;
          fetch_ready <= 1'b1;
          state       <= ST_IDLE;
          if (addr_hit) begin
            instruction <= mem[addr_q[IDX_W-1:0]];
            fetch_fault <= 1'b0;
          end else begin
            instruction <= FAULT_INST;
            fetch_fault <= 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          fetch_ready <= 1'b0;
          load_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_mem_ctrl.sv
// Self-checking bench for instruction_mem_ctrl.
// A behavioural model (image array + word count) predicts every fetch
// result; predictions go through an expected queue and are compared against
// the inst_valid responses. Inputs change 1 ns after the rising edge and
// outputs are sampled at that same point.
module tb_instruction_mem_ctrl;

  localparam int                DATA_W      = 32;
  localparam int                ADDR_W      = 8;
  localparam int                DEPTH       = 8;
  localparam int                WAIT_CYCLES = 3;
  localparam logic [DATA_W-1:0] FAULT_INST  = '0;
  localparam int                CNT_W       = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              load_en    = 1'b0;
  logic              load_valid = 1'b0;
  logic [DATA_W-1:0] load_data  = '0;
  logic              load_ready;
  logic              load_done;
  logic [CNT_W-1:0]  words_loaded;
  logic              fetch_req  = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic              fetch_ready;
  logic              inst_valid;
  logic [DATA_W-1:0] instruction;
  logic              fetch_fault;
  logic [1:0]        state_dbg;

  instruction_mem_ctrl #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES),
    .FAULT_INST  (FAULT_INST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_en      (load_en),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .load_done    (load_done),
    .words_loaded (words_loaded),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ready  (fetch_ready),
    .inst_valid   (inst_valid),
    .instruction  (instruction),
    .fetch_fault  (fetch_fault),
    .state_dbg    (state_dbg)
  );

  // ---------------- model / scoreboard ----------------
  logic [DATA_W-1:0] mem_model [DEPTH];
  int                model_words = 0;
  logic [DATA_W:0]   exp_q [$];   // {fault, instruction}
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"},   load_ready,   0);
    check({tag, "_load_done"},    load_done,    0);
    check({tag, "_words_loaded"}, words_loaded, 0);
    check({tag, "_fetch_ready"},  fetch_ready,  0);
    check({tag, "_inst_valid"},   inst_valid,   0);
    check({tag, "_instruction"},  instruction,  0);
    check({tag, "_fetch_fault"},  fetch_fault,  0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    load_en = 1'b0; load_valid = 1'b0; fetch_req = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    check("reset_state_idle", state_dbg, 0);
    rst = 1'b0;
    model_words = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (fetch_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (fetch_ready !== 1'b1) check("idle_timeout", fetch_ready, 1);
  endtask

  task automatic do_fetch(input logic [ADDR_W-1:0] a);
    int lat = 0;
    int idx = int'(a);
    logic [DATA_W:0] e;
    wait_idle();
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
    fetch_addr = ADDR_W'($urandom);   // must be ignored after acceptance
    if (idx < model_words) exp_q.push_back({1'b0, mem_model[idx]});
    else                   exp_q.push_back({1'b1, FAULT_INST});
    while (inst_valid !== 1'b1 && lat < 40) begin
      check("fetch_ready_busy", fetch_ready, 0);
      tick();
      lat++;
    end
    check("fetch_latency", lat, WAIT_CYCLES + 1);
    e = exp_q.pop_front();
    check("inst_valid", inst_valid, 1);
    check("fetch_fault", fetch_fault, e[DATA_W]);
    check("instruction", instruction, e[DATA_W-1:0]);
    tick();
    check("inst_valid_pulse", inst_valid, 0);
    check("instruction_hold", instruction, e[DATA_W-1:0]);
  endtask

  // Offers n_beats words (random gaps unless fixed), then drops load_en.
  // Fixed data is (i+1)*0x11111111 for beat i.
  task automatic do_load(input int n_beats, input bit fixed, input bit with_fetch);
    int ptr = 0;
    int offered = 0;
    int cyc = 0;
    bit done = 1'b0;
    bit beat;
    bit exit_exp;
    wait_idle();
    load_en = 1'b1;
    load_valid = 1'b0;
    if (with_fetch) begin
      fetch_req  = 1'b1;
      fetch_addr = '0;
    end
    tick();
    fetch_req = 1'b0;
    while (!done && cyc < 100) begin
      check("load_ready", load_ready, ptr < DEPTH);
      check("load_fetch_ready", fetch_ready, 0);
      check("load_no_inst_valid", inst_valid, 0);
      load_valid = 1'b0;
      if (offered < n_beats) begin
        if (fixed || $urandom_range(0, 3) != 0) begin
          load_valid = 1'b1;
          load_data  = fixed ? DATA_W'((offered + 1) * 32'h11111111) : DATA_W'($urandom);
          if (offered == n_beats - 1 && $urandom_range(0, 1) == 1) load_en = 1'b0;
        end
      end else begin
        load_en = 1'b0;
      end
      beat = load_valid && (ptr < DEPTH);
      if (beat) begin
        mem_model[ptr] = load_data;
        ptr++;
        offered++;
      end
      exit_exp = !load_en || (beat && ptr == DEPTH);
      tick();
      if (exit_exp) begin
        check("load_done", load_done, 1);
        check("words_loaded", words_loaded, ptr);
        check("load_ready_after", load_ready, 0);
        model_words = ptr;
        done = 1'b1;
      end else begin
        check("load_done_early", load_done, 0);
      end
      cyc++;
    end
    if (!done) check("load_timeout", done, 1);
    load_en = 1'b0;
    load_valid = 1'b0;
    tick();
    check("load_done_pulse", load_done, 0);
    check("load_no_inst_valid_end", inst_valid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen_valid;

    // 1: reset, then a fetch with nothing loaded faults
    do_reset();
    do_fetch(8'd0);

    // 2: four fixed words, in-range and out-of-range fetches
    do_load(4, 1'b1, 1'b0);
    check("words4", words_loaded, 4);
    do_fetch(8'd2);
    do_fetch(8'd4);

    // 3: ten beats into an eight-word memory; no aliasing above DEPTH
    do_load(10, 1'b1, 1'b0);
    check("words_full", words_loaded, DEPTH);
    do_fetch(8'd7);
    do_fetch(8'd8);
    do_fetch(8'd255);
    do_fetch(8'd0);

    // 5: load and fetch requested together: load wins, fetch retried later
    do_load(3, 1'b0, 1'b1);
    do_fetch(8'd1);

    // 6a: reset while waiting for a fetch response
    do_load(5, 1'b0, 1'b0);
    wait_idle();
    fetch_req = 1'b1; fetch_addr = 8'd1;
    tick();
    fetch_req = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_wait");
    seen_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (inst_valid === 1'b1) seen_valid = 1'b1;
    end
    rst = 1'b0;
    model_words = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (inst_valid === 1'b1) seen_valid = 1'b1;
    end
    check("rst_wait_no_valid", seen_valid, 0);
    do_fetch(8'd1);

    // 6b: reset after three load beats discards the partial image
    do_load(6, 1'b0, 1'b0);
    wait_idle();
    load_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = DATA_W'($urandom);
      tick();
    end
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_load");
    load_en = 1'b0; load_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_words = 0;
    do_fetch(8'd0);
    do_load(6, 1'b0, 1'b0);
    do_fetch(8'd5);
    do_fetch(8'd6);

    // randomized mix of reloads and fetches
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        do_load($urandom_range(0, 10), 1'b0, 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 7) == 0) begin
        do_fetch(ADDR_W'($urandom));
      end else begin
        do_fetch(ADDR_W'($urandom_range(0, DEPTH + 2)));
      end
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
